// File: rtl/andrewm_uart_to_parallel.sv
// andrewm_uart_to_parallel
// 8N1 UART receiver. It oversamples rx at CLKS_PER_BIT clocks per bit and
// samples each bit at its middle. Each recovered byte goes into a one-entry
// holding register that the consumer drains with a valid/ready handshake.
// frame_err and overrun are sticky until clr_err.
module andrewm_uart_to_parallel #(
  parameter int CLKS_PER_BIT = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rd_ready,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_busy;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_ovr;

  logic          w_tick;
  logic          w_read;
  logic          w_stop_tick;
  logic          w_deliver;
  logic          w_ferr_set;
  logic          w_ovr_set;

  assign w_tick      = (r_cnt == '0);
  assign w_read      = r_valid & rd_ready;
  assign w_stop_tick = (r_state == S_STOP) & w_tick;
  assign w_deliver   = w_stop_tick & r_sync2;
  assign w_ferr_set  = w_stop_tick & ~r_sync2;
  // A completed byte is dropped only when the old one is still held and
  // is not being read in this very cycle.
  assign w_ovr_set   = w_deliver & r_valid & ~w_read;

  // Two-flop synchronizer for the asynchronous serial line; it resets to idle-high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, whatever the statement order.
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM: start detection, mid-bit sampling, data shifting and stop check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // armed blocks retriggering on a line held low (break) until it
          // has been seen high again.
          if (r_armed && !r_sync2) begin
            r_state <= S_START;
            r_armed <= 1'b0;
            r_cnt   <= HALF;
            r_busy  <= 1'b1;
          end else if (r_sync2) begin
            r_armed <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!r_sync2) begin
              r_state   <= S_DATA;
              r_cnt     <= FULL;
              r_bit_idx <= 3'd0;
            end else begin
              // The start bit did not hold to mid-bit, so this was a glitch.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            r_cnt     <= FULL;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        S_STOP: begin
          // Going back to IDLE at mid-stop leaves half a bit to re-arm
          // before a back-to-back start edge.
          if (w_tick) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register and handshake: a read and a delivery in the same cycle
  // are a hand-off, not an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      if (w_deliver && (!r_valid || w_read)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_read) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Sticky error flags: a new error event takes priority over clr_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (clr_err) begin
        r_ferr <= 1'b0;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (clr_err) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = r_busy;

endmodule
